cl_ocl_axil_master: RTL and testbench

- AXI-Lite master (initiator) that drives the OCL-style 32-bit AXI-Lite slave register ports from a simple command/data stream interface.
- Used in CL self-test and bring-up logic, and as the bench-side driver for register/BRAM-window slaves.
- Each command issues 1..256 single-beat AXI-L transactions to one fixed address. Target slaves auto-increment an internal pointer per access, so the address never changes.
- Write data arrives per beat on a stream; read data and responses leave per beat on a stream.

---
 rtl/cl_ocl_axil_pkg.sv | 26 ++
 rtl/cl_axil_phase_timer.sv | 31 +++
 rtl/cl_ocl_axil_master.sv | 196 +++++++++++++++++++
 tb/tb_cl_ocl_axil_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_ocl_axil_pkg.sv
// Shared types and constants for the OCL AXI-Lite master.
package cl_ocl_axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } axil_mst_state_t;

  typedef struct packed {
    logic                   write;
    logic [AXIL_ADDR_W-1:0] addr;
    logic [7:0]             len;
  } axil_cmd_t;

endpackage

// File: rtl/cl_axil_phase_timer.sv
// Saturating per-phase stall counter; pulses expired_o on the cycle it reaches LIMIT.
module cl_axil_phase_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (cnt_q != LIM)
      cnt_d = cnt_q + 1'b1;
  end

  assign expired_o = !clr_i && (cnt_q == LIM - 1'b1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cl_ocl_axil_master.sv
// AXI-Lite master: one command issues 1..256 single-beat transactions to a fixed address.
module cl_ocl_axil_master
  import cl_ocl_axil_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk_main_a0,
  input  logic                rst_main,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_last,
  output logic                busy,
  output logic                timeout_err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  axil_mst_state_t     state_q, state_d;
  axil_cmd_t           cmd_q, cmd_d;
  logic [7:0]          beat_q, beat_d;
  logic                held_q, held_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]          resp_q, resp_d;
  logic                to_q, to_d;
  logic                cmd_rdy_c, aw_ok, w_ok, tmr_clr, tmr_expired;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    beat_d    = beat_q;
    held_d    = held_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    to_d      = to_q;
    cmd_rdy_c = 1'b0;
    wd_ready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    aw_ok     = 1'b0;
    w_ok      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy_c = 1'b1;
        if (cmd_valid) begin
          cmd_d   = '{write: cmd_write, addr: cmd_addr, len: cmd_len};
          beat_d  = '0;
          to_d    = 1'b0;
          state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        wd_ready = !held_q;
        if (wd_valid && !held_q) begin
          wdata_d = wd_data;
          wstrb_d = wd_strb;
          held_d  = 1'b1;
        end
        // AW and W complete independently; both valids wait for registered data
        m_awvalid = held_q && !aw_done_q;
        m_wvalid  = held_q && !w_done_q;
        aw_ok     = aw_done_q || (m_awvalid && m_awready);
        w_ok      = w_done_q  || (m_wvalid && m_wready);
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) begin
          held_d    = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          resp_d  = m_bresp;
          rdata_d = '0;
          state_d = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          resp_d  = m_rresp;
          rdata_d = m_rdata;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        rsp_last  = (beat_q == cmd_q.len);
        if (rsp_ready) begin
          if (rsp_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = cmd_q.write ? ST_WR_REQ : ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmr_expired) to_d = 1'b1;
  end

  // Only genuine AXI-side stalls count; waiting on wd or rsp streams does not
  assign tmr_clr = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_RSP) ||
                   ((state_q == ST_WR_REQ) && !held_q);

  cl_axil_phase_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk_i     (clk_main_a0),
    .rst_i     (rst_main),
    .clr_i     (tmr_clr),
    .expired_o (tmr_expired)
  );

  assign cmd_ready   = cmd_rdy_c && !rst_main;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = to_q;
  assign m_awaddr    = cmd_q.addr;
  assign m_araddr    = cmd_q.addr;
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign rsp_data    = rdata_q;
  assign rsp_resp    = resp_q;

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      beat_q    <= '0;
      held_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      beat_q    <= beat_d;
      held_q    <= held_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      to_q      <= to_d;
    end
  end

endmodule

// File: tb/tb_cl_ocl_axil_master.sv
// Directed + randomized bench with a behavioural AXI-L slave and per-command beat model.
module tb_cl_ocl_axil_master;
  import cl_ocl_axil_pkg::*;

  localparam int TO  = 64;
  localparam int LIM = 4 * TO + 200;

  logic        clk = 1'b0;
  logic        rst_main;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rsp_valid, rsp_ready, rsp_last, busy, timeout_err;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cl_ocl_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_main_a0(clk), .rst_main(rst_main),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_last(rsp_last), .busy(busy), .timeout_err(timeout_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: configurable per-channel latency, logs every accepted AW/W/AR.
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  logic [31:0] aw_log[$], w_log[$], ar_log[$], rd_q[$];
  logic [3:0]  strb_log[$];
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int aw_hs, w_hs, ar_hs, b_issue, r_issue;
  int aw_runs = 0, w_runs = 0, b_cnt = 0, overlap_viol = 0;
  bit b_fire, r_fire, prev_awv, prev_wv;

  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(negedge clk);
      if (rst_main) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_issue = 0; r_issue = 0;
        b_fire = 0; r_fire = 0; prev_awv = 0; prev_wv = 0;
      end else begin
        if (rsp_valid && (m_awvalid || m_arvalid)) overlap_viol++;
        if (m_awvalid && !prev_awv) aw_runs++;
        if (m_wvalid && !prev_wv) w_runs++;
        prev_awv = m_awvalid;
        prev_wv  = m_wvalid;
        if (m_awready) begin m_awready = 0; aw_hs++; end
        else if (m_awvalid) begin
          if (aw_wait >= aw_lat) begin m_awready = 1; aw_log.push_back(m_awaddr); aw_wait = 0; end
          else aw_wait++;
        end
        if (m_wready) begin m_wready = 0; w_hs++; end
        else if (m_wvalid) begin
          if (w_wait >= w_lat) begin
            m_wready = 1; w_log.push_back(m_wdata); strb_log.push_back(m_wstrb); w_wait = 0;
          end else w_wait++;
        end
        if (m_arready) begin m_arready = 0; ar_hs++; end
        else if (m_arvalid) begin
          if (ar_wait >= ar_lat) begin m_arready = 1; ar_log.push_back(m_araddr); ar_wait = 0; end
          else ar_wait++;
        end
        if (m_bvalid) begin
          if (b_fire) begin m_bvalid = 0; b_fire = 0; b_cnt++; end
          else if (m_bready) b_fire = 1;
        end else if (b_issue < aw_hs && b_issue < w_hs) begin
          if (b_wait >= b_lat) begin
            m_bvalid = 1; m_bresp = bresp_cfg; b_issue++; b_wait = 0; b_fire = m_bready;
          end else b_wait++;
        end
        if (m_rvalid) begin
          if (r_fire) begin m_rvalid = 0; r_fire = 0; end
          else if (m_rready) r_fire = 1;
        end else if (r_issue < ar_hs) begin
          if (r_wait >= r_lat) begin
            m_rvalid = 1; m_rresp = rresp_cfg;
            m_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBADBAD00;
            r_issue++; r_wait = 0; r_fire = m_rready;
          end else r_wait++;
        end
      end
    end
  end

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input int len);
    int cyc;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
    cyc = 0;
    while (!cmd_ready && cyc < LIM) begin @(negedge clk); cyc++; end
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    check("busy_after_accept", busy, 1);
    check("timeout_clr_on_accept", timeout_err, 0);
  endtask

  // Model: len+1 beats; each write beat = one AW at addr + one W carrying beat i's data.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len, input bit rnd,
                         input logic [31:0] base, input logic [31:0] step, input int stall_n);
    logic [31:0] dq[$], eq[$];
    logic [3:0]  sq[$];
    logic [1:0]  eresp;
    int n, aw0, w0, b0, cyc;
    n = len + 1;
    aw0 = aw_runs; w0 = w_runs; b0 = b_cnt;
    aw_log.delete(); w_log.delete(); strb_log.delete(); ar_log.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back(rnd ? $urandom : base + step * i);
      sq.push_back(rnd ? 4'($urandom_range(0, 15)) : 4'hF);
      eq.push_back(wr ? 32'h0 : dq[i]);
      if (!wr) rd_q.push_back(dq[i]);
    end
    eresp = wr ? bresp_cfg : rresp_cfg;
    issue_cmd(wr, addr, len);
    fork
      if (wr) begin
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          wd_valid = 1; wd_data = dq[i]; wd_strb = sq[i];
          cyc = 0;
          while (!wd_ready && cyc < LIM) begin @(negedge clk); cyc++; end
          if (!wd_ready) break;
          @(posedge clk);
        end
        #1 wd_valid = 0;
      end
      begin
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
          int c2 = 0;
          while (!rsp_valid && c2 < LIM) begin @(negedge clk); c2++; end
          check($sformatf("rsp_valid[%0d]", i), rsp_valid, 1);
          if (!rsp_valid) break;
          if (i == 0) begin
            for (int k = 0; k < stall_n; k++) begin
              check("stall_hold", {rsp_valid, rsp_last, rsp_resp, rsp_data},
                    {1'b1, (n == 1), eresp, eq[0]});
              @(negedge clk);
            end
          end
          check($sformatf("rsp_data[%0d]", i), rsp_data, eq[i]);
          check($sformatf("rsp_resp[%0d]", i), rsp_resp, eresp);
          check($sformatf("rsp_last[%0d]", i), rsp_last, (i == n - 1));
          rsp_ready = 1;
          @(negedge clk);
          rsp_ready = 0;
        end
      end
    join
    check("busy_after_cmd", busy, 0);
    if (wr) begin
      check("aw_count", aw_log.size(), n);
      check("w_count", w_log.size(), n);
      for (int i = 0; i < n && i < aw_log.size() && i < w_log.size(); i++) begin
        check($sformatf("awaddr[%0d]", i), aw_log[i], addr);
        check($sformatf("wdata[%0d]", i), w_log[i], dq[i]);
        check($sformatf("wstrb[%0d]", i), strb_log[i], sq[i]);
      end
      check("aw_runs", aw_runs - aw0, n);
      check("w_runs", w_runs - w0, n);
      check("b_count", b_cnt - b0, n);
    end else begin
      check("ar_count", ar_log.size(), n);
      for (int i = 0; i < n && i < ar_log.size(); i++)
        check($sformatf("araddr[%0d]", i), ar_log[i], addr);
    end
  endtask

  initial begin
    int cyc;
    rst_main = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0; rsp_ready = 0;
    #12;
    check("reset_outputs", {cmd_ready, wd_ready, rsp_valid, rsp_last, busy, timeout_err,
                            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check("reset_rsp_data", {rsp_data, rsp_resp}, 0);
    @(negedge clk); @(negedge clk);
    rst_main = 0;
    #1 check("idle_cmd_ready", cmd_ready, 1);

    run_cmd(1, 32'h500, 3, 0, 32'hDEAD0000, 32'h1, 0);
    run_cmd(0, 32'h500, 1, 0, 32'h11, 32'h11, 0);

    aw_lat = 0; w_lat = 3;
    run_cmd(1, 32'h504, 0, 1, 0, 0, 0);
    aw_lat = 3; w_lat = 0;
    run_cmd(1, 32'h508, 0, 1, 0, 0, 0);
    aw_lat = 0; w_lat = 0;

    run_cmd(0, 32'h600, 2, 1, 0, 0, 5);
    run_cmd(1, 32'h604, 1, 1, 0, 0, 5);

    for (int t = 0; t < 4; t++) begin
      aw_lat = $urandom_range(0, 4); w_lat = $urandom_range(0, 4);
      b_lat = $urandom_range(0, 4); ar_lat = $urandom_range(0, 4); r_lat = $urandom_range(0, 4);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      run_cmd(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 5), 1, 0, 0,
              $urandom_range(0, 3));
    end
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
    rresp_cfg = RESP_OKAY;
    check("no_timeout_normal", timeout_err, 0);

    b_lat = TO + 10; bresp_cfg = RESP_SLVERR;
    run_cmd(1, 32'h700, 0, 1, 0, 0, 0);
    check("timeout_set", timeout_err, 1);
    b_lat = 0; bresp_cfg = RESP_OKAY;
    run_cmd(0, 32'h700, 0, 1, 0, 0, 0);

    r_lat = 20;
    rd_q.push_back(32'h5A5A5A5A);
    issue_cmd(0, 32'h800, 3);
    cyc = 0;
    while (!m_rready && cyc < LIM) begin @(negedge clk); cyc++; end
    check("reached_rd_resp", m_rready, 1);
    rst_main = 1;
    #1 check("midreset_outputs", {m_awvalid, m_wvalid, m_arvalid, m_rready, m_bready,
                                  rsp_valid, busy, cmd_ready}, 0);
    @(negedge clk); @(negedge clk);
    rst_main = 0;
    rd_q.delete(); r_lat = 0;
    #1 check("post_reset_ready", {cmd_ready, busy}, 2'b10);
    run_cmd(0, 32'h804, 0, 1, 0, 0, 0);

    check("no_overlap", overlap_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
